// File: rtl/decode_pipe_if.sv
// decode_pipe_if: request/response bundle for decode_pipe.
//   Request side : flush, in_valid, in_ready, in_sel, in_en, in_mode
//   Response side: out_valid, out_ready, out_vec, out_sel
// Modports:
//   slave  - the decoder block itself
//   master - the environment driving requests and consuming results
interface decode_pipe_if #(
  parameter int IN_W = 3
);
  localparam int OUT_W = 1 << IN_W;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sel;
  logic             in_en;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;
  logic [IN_W-1:0]  out_sel;

  modport slave (
    input  flush, in_valid, in_sel, in_en, in_mode, out_ready,
    output in_ready, out_valid, out_vec, out_sel
  );

  modport master (
    output flush, in_valid, in_sel, in_en, in_mode, out_ready,
    input  in_ready, out_valid, out_vec, out_sel
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: parametrised select decoder with a 2-entry valid/ready
// output queue.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (clears control and data)
//   bus   - decode_pipe_if.slave:
//             flush                  drop every buffered result
//             in_valid/in_ready      request handshake
//             in_sel/in_en/in_mode   select, enable, decode mode
//             out_valid/out_ready    result handshake
//             out_vec/out_sel        head result and its echoed select
// Modes: 00 one-hot, 01 thermometer, 10 inverted one-hot, 11 all ones.
// in_en=0 yields an all-zero vector but is still queued as a result.
module decode_pipe #(
  parameter int IN_W = 3
) (
  input logic         clk,
  input logic         rst_n,
  decode_pipe_if.slave bus
);
  localparam int OUT_W = 1 << IN_W;

  function automatic logic [OUT_W-1:0] decode(
    input logic [IN_W-1:0] s,
    input logic            en,
    input logic [1:0]      mode
  );
    logic [OUT_W-1:0] v;
    v = '0;
    if (en) begin
      for (int i = 0; i < OUT_W; i++) begin
        case (mode)
          2'b00:   v[i] = (i == int'(s));
          2'b01:   v[i] = (i <= int'(s));
          2'b10:   v[i] = (i != int'(s));
          default: v[i] = 1'b1;
        endcase
      end
    end
    return v;
  endfunction

  // Stage p0: combinational decode of the incoming request
  logic [OUT_W-1:0] dec_vec_p0;
  logic             push_p0;
  logic             pop_p0;

  // Stage p1: queue storage (head feeds the outputs directly)
  logic [OUT_W-1:0] head_vec_p1;
  logic [IN_W-1:0]  head_sel_p1;
  logic [OUT_W-1:0] tail_vec_p1;
  logic [IN_W-1:0]  tail_sel_p1;
  logic [1:0]       count_p1;

  assign dec_vec_p0 = decode(bus.in_sel, bus.in_en, bus.in_mode);

  // in_ready looks only at registered occupancy so there is no
  // combinational path from out_ready back to in_ready.
  assign bus.in_ready  = (count_p1 != 2'd2);
  assign bus.out_valid = (count_p1 != 2'd0);
  assign bus.out_vec   = head_vec_p1;
  assign bus.out_sel   = head_sel_p1;

  assign push_p0 = bus.in_valid & bus.in_ready;
  assign pop_p0  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_p1    <= 2'd0;
      head_vec_p1 <= '0;
      head_sel_p1 <= '0;
      tail_vec_p1 <= '0;
      tail_sel_p1 <= '0;
    end else if (bus.flush) begin
      // Push and pop in a flush cycle are both discarded.
      count_p1 <= 2'd0;
    end else begin
      case (count_p1)
        2'd0: begin
          if (push_p0) begin
            head_vec_p1 <= dec_vec_p0;
            head_sel_p1 <= bus.in_sel;
            count_p1    <= 2'd1;
          end
        end
        2'd1: begin
          if (push_p0 && pop_p0) begin
            // Head leaves and the new entry takes its place.
            head_vec_p1 <= dec_vec_p0;
            head_sel_p1 <= bus.in_sel;
          end else if (push_p0) begin
            tail_vec_p1 <= dec_vec_p0;
            tail_sel_p1 <= bus.in_sel;
            count_p1    <= 2'd2;
          end else if (pop_p0) begin
            count_p1 <= 2'd0;
          end
        end
        2'd2: begin
          // Full: no push possible; a pop promotes the tail.
          if (pop_p0) begin
            head_vec_p1 <= tail_vec_p1;
            head_sel_p1 <= tail_sel_p1;
            count_p1    <= 2'd1;
          end
        end
        default: begin
          count_p1 <= 2'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: bench for decode_pipe with IN_W=3 and IN_W=4 instances.
// The IN_W=3 instance is tracked by a queue-based reference model.
module tb_decode_pipe;
  logic clk;
  logic rst_n;

  decode_pipe_if #(.IN_W(3)) bus3 ();
  decode_pipe_if #(.IN_W(4)) bus4 ();

  decode_pipe #(.IN_W(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  decode_pipe #(.IN_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] vec;
    logic [3:0]  sel;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference decode using plain shift arithmetic.
  function automatic logic [15:0] ref_dec(input int w, input int s, input bit en, input int mode);
    int all;
    int r;
    all = (1 << (1 << w)) - 1;
    if (!en) return 16'h0000;
    case (mode)
      0:       r = 1 << s;
      1:       r = (2 << s) - 1;
      2:       r = ~(1 << s) & all;
      default: r = all;
    endcase
    return r[15:0];
  endfunction

  // One clock; updates the IN_W=3 model from the inputs in force at the edge.
  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push  = (bus3.in_valid === 1'b1) && (mq.size() < 2);
    pop   = (mq.size() != 0) && (bus3.out_ready === 1'b1);
    e.vec = ref_dec(3, int'(bus3.in_sel), bus3.in_en, int'(bus3.in_mode));
    e.sel = {1'b0, bus3.in_sel};
    @(posedge clk);
    if (rst_n === 1'b0 || bus3.flush === 1'b1) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic req3(input int sel, input int mode, input bit en);
    bus3.in_valid = 1'b1;
    bus3.in_sel   = sel[2:0];
    bus3.in_mode  = mode[1:0];
    bus3.in_en    = en;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hs3: valid=%b ready=%b want 0/1", bus3.out_valid, bus3.in_ready);
    end
    n_cmp++;
    if (bus3.out_vec !== 8'h00 || bus3.out_sel !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_data3: vec=%h sel=%0d want 00/0", bus3.out_vec, bus3.out_sel);
    end
    n_cmp++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.out_vec !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset4: valid=%b ready=%b vec=%h want 0/1/0000", bus4.out_valid, bus4.in_ready, bus4.out_vec);
    end
  endtask

  task automatic test_first();
    bus3.out_ready = 1'b1;
    req3(5, 0, 1'b1);
    tick();
    bus3.in_valid = 1'b0;
    n_cmp++;
    if (bus3.out_valid !== 1'b1 || bus3.out_vec !== 8'b0010_0000 || bus3.out_sel !== 3'd5) begin
      n_bad++;
      $display("FAIL first: valid=%b vec=%b sel=%0d want 1/00100000/5", bus3.out_valid, bus3.out_vec, bus3.out_sel);
    end
    tick();
    n_cmp++;
    if (bus3.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_drain: valid=%b want 0", bus3.out_valid);
    end
  endtask

  task automatic test_modes();
    int   modes[5] = '{1, 2, 3, 0, 3};
    bit   ens[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] exps[5] = '{8'b0000_0111, 8'b1111_1011, 8'hFF, 8'h00, 8'h00};
    bus3.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req3(2, modes[k], ens[k]);
      tick();
      bus3.in_valid = 1'b0;
      n_cmp++;
      if (bus3.out_valid !== 1'b1 || bus3.out_vec !== exps[k] || bus3.out_sel !== 3'd2) begin
        n_bad++;
        $display("FAIL mode%0d_en%0d: valid=%b vec=%h sel=%0d want 1/%h/2", modes[k], ens[k],
                 bus3.out_valid, bus3.out_vec, bus3.out_sel, exps[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bus3.out_ready = 1'b0;
    req3(1, 0, 1'b1);
    tick();
    req3(6, 0, 1'b1);
    tick();
    req3(3, 0, 1'b1);
    n_cmp++;
    if (bus3.in_ready !== 1'b0 || bus3.out_vec !== 8'h02) begin
      n_bad++;
      $display("FAIL bp_full: ready=%b vec=%h want 0/02", bus3.in_ready, bus3.out_vec);
    end
    tick();
    tick();
    n_cmp++;
    if (bus3.in_ready !== 1'b0 || bus3.out_valid !== 1'b1 || bus3.out_vec !== 8'h02 || bus3.out_sel !== 3'd1) begin
      n_bad++;
      $display("FAIL bp_hold: ready=%b valid=%b vec=%h sel=%0d want 0/1/02/1", bus3.in_ready,
               bus3.out_valid, bus3.out_vec, bus3.out_sel);
    end
    bus3.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus3.out_vec !== 8'h40 || bus3.out_sel !== 3'd6 || bus3.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second: vec=%h sel=%0d ready=%b want 40/6/1", bus3.out_vec, bus3.out_sel, bus3.in_ready);
    end
    tick();
    bus3.in_valid = 1'b0;
    n_cmp++;
    if (bus3.out_valid !== 1'b1 || bus3.out_vec !== 8'h08 || bus3.out_sel !== 3'd3) begin
      n_bad++;
      $display("FAIL bp_third: valid=%b vec=%h sel=%0d want 1/08/3", bus3.out_valid, bus3.out_vec, bus3.out_sel);
    end
    tick();
    n_cmp++;
    if (bus3.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty: valid=%b want 0", bus3.out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_v;
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req3(i, 0, 1'b1);
      tick();
      exp_v = 8'h01 << i;
      n_cmp++;
      if (bus3.out_valid !== 1'b1 || bus3.out_vec !== exp_v || bus3.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL stream%0d: valid=%b vec=%h ready=%b want 1/%h/1", i, bus3.out_valid,
                 bus3.out_vec, bus3.in_ready, exp_v);
      end
    end
    bus3.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus3.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_end: valid=%b want 0", bus3.out_valid);
    end
  endtask

  task automatic test_flush();
    // Full queue flushed with a concurrent request.
    bus3.out_ready = 1'b0;
    req3(4, 0, 1'b1);
    tick();
    req3(5, 0, 1'b1);
    tick();
    req3(7, 3, 1'b1);
    bus3.flush = 1'b1;
    tick();
    bus3.flush    = 1'b0;
    bus3.in_valid = 1'b0;
    n_cmp++;
    if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_full: valid=%b ready=%b want 0/1", bus3.out_valid, bus3.in_ready);
    end
    // One entry queued; the flush-cycle request is accepted but dropped.
    req3(1, 0, 1'b1);
    tick();
    req3(6, 1, 1'b1);
    bus3.flush     = 1'b1;
    bus3.out_ready = 1'b1;
    tick();
    bus3.flush    = 1'b0;
    bus3.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_drop: valid=%b ready=%b want 0/1", bus3.out_valid, bus3.in_ready);
    end
  endtask

  task automatic test_mid_reset();
    bus3.out_ready = 1'b0;
    req3(6, 2, 1'b1);
    tick();
    bus3.in_valid = 1'b0;
    n_cmp++;
    if (bus3.out_valid !== 1'b1 || bus3.out_vec !== 8'hBF) begin
      n_bad++;
      $display("FAIL pre_rst: valid=%b vec=%h want 1/bf", bus3.out_valid, bus3.out_vec);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (bus3.out_valid !== 1'b0 || bus3.out_vec !== 8'h00 || bus3.out_sel !== 3'd0 || bus3.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rst: valid=%b vec=%h sel=%0d ready=%b want 0/00/0/1", bus3.out_valid,
               bus3.out_vec, bus3.out_sel, bus3.in_ready);
    end
  endtask

  task automatic test_in4();
    int sels[3]  = '{15, 9, 0};
    int modes[3] = '{1, 0, 2};
    logic [15:0] exp_v;
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_sel    = 4'd7;
    bus4.in_mode   = 2'b00;
    bus4.in_en     = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (bus4.out_valid !== 1'b0 || bus4.out_vec !== 16'h0000 || bus4.out_sel !== 4'd0) begin
      n_bad++;
      $display("FAIL rst4: valid=%b vec=%h sel=%0d want 0/0000/0", bus4.out_valid, bus4.out_vec, bus4.out_sel);
    end
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus4.in_valid = 1'b1;
      bus4.in_sel   = sels[k][3:0];
      bus4.in_mode  = modes[k][1:0];
      tick();
      bus4.in_valid = 1'b0;
      exp_v = ref_dec(4, sels[k], 1'b1, modes[k]);
      n_cmp++;
      if (bus4.out_valid !== 1'b1 || bus4.out_vec !== exp_v || bus4.out_sel !== sels[k][3:0]) begin
        n_bad++;
        $display("FAIL w4_sel%0d: valid=%b vec=%h sel=%0d want 1/%h/%0d", sels[k], bus4.out_valid,
                 bus4.out_vec, bus4.out_sel, exp_v, sels[k]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit exp_valid;
    for (int c = 0; c < 400; c++) begin
      bus3.in_valid  = ($urandom_range(0, 3) != 0);
      bus3.in_sel    = 3'($urandom_range(0, 7));
      bus3.in_mode   = 2'($urandom_range(0, 3));
      bus3.in_en     = ($urandom_range(0, 5) != 0);
      bus3.out_ready = ($urandom_range(0, 2) != 0);
      bus3.flush     = ($urandom_range(0, 19) == 0);
      exp_valid = (mq.size() != 0);
      n_cmp++;
      if (bus3.out_valid !== exp_valid || bus3.in_ready !== (mq.size() < 2)) begin
        n_bad++;
        $display("FAIL rand_hs c%0d: valid=%b ready=%b want %b/%b", c, bus3.out_valid,
                 bus3.in_ready, exp_valid, (mq.size() < 2));
      end
      if (exp_valid) begin
        n_cmp++;
        if ({8'h00, bus3.out_vec} !== mq[0].vec || {1'b0, bus3.out_sel} !== mq[0].sel) begin
          n_bad++;
          $display("FAIL rand_data c%0d: vec=%h sel=%0d want %h/%0d", c, bus3.out_vec,
                   bus3.out_sel, mq[0].vec[7:0], mq[0].sel);
        end
      end
      tick();
    end
    bus3.flush    = 1'b0;
    bus3.in_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus3.flush     = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.in_sel    = '0;
    bus3.in_en     = 1'b1;
    bus3.in_mode   = 2'b00;
    bus3.out_ready = 1'b1;
    bus4.flush     = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_sel    = '0;
    bus4.in_en     = 1'b1;
    bus4.in_mode   = 2'b00;
    bus4.out_ready = 1'b1;
    test_reset();
    test_first();
    test_modes();
    test_backpressure();
    test_streaming();
    test_flush();
    test_mid_reset();
    test_in4();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3-to-8 one-hot decoder.
- Decodes an IN_W-bit select into a 2^IN_W-bit vector in one of four runtime modes.
- Result is buffered in a 2-entry valid/ready output queue, so the block can sit between pipeline stages that stall. Typical uses: register-file write-enable generation, bank/way select.
- Flush drops all buffered results.

Parameters:
- IN_W, 3, select width; output width OUT_W = 2^IN_W is a derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- flush  input  1  discard all buffered entries this cycle
- in_valid  input  1  upstream has a request
- in_ready  output  1  block can accept a request this cycle
- in_sel  input  IN_W  select index
- in_en  input  1  decode enable; 0 forces an all-zero result but still counts as a transaction
- in_mode  input  2  00 one-hot, 01 thermometer, 10 inverted one-hot, 11 broadcast
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head this cycle
- out_vec  output  OUT_W  decoded vector of head entry
- out_sel  output  IN_W  in_sel echoed for the head entry

Behaviour:
- Decode function, for s = in_sel and bit i of the result:
  - mode 00: bit i = (i==s).
  - mode 01: bit i = (i<=s).
  - mode 10: bit i = (i!=s).
  - mode 11: all ones.
  - in_en=0 overrides every mode: all zeros.
- Decode is evaluated combinationally on the input side and captured at push time. Entries are never re-decoded.
- Storage: 2-entry FIFO (head, tail) plus a 2-bit occupancy count, range 0..2.
- Push = in_valid & in_ready.
- Pop = out_valid & out_ready.
- in_ready = (count != 2); depends only on registered state, never combinationally on out_ready.
- out_valid = (count != 0). out_vec and out_sel come from the head entry and are registered outputs.
- Latency: a request pushed in cycle N appears at the outputs in cycle N+1 if the FIFO was empty. Throughput is 1 per cycle when out_ready is held high.
- Ordering is strict FIFO.
- count==1 with push and pop in the same cycle: head is replaced by the new entry, count stays 1.
- count==2: in_ready=0 even if out_ready=1 that cycle. A pop frees one slot, visible the next cycle.
- count==0 with pop attempted: impossible, since out_valid=0; no state change.
- Output stability: while out_valid=1 and out_ready=0, out_vec and out_sel hold constant.
- flush=1: count<=0 next cycle. Any push in the same cycle is dropped and any pop is ignored. in_ready is unaffected in the flush cycle, so upstream may see an accepted-but-dropped request; this is intended, because upstream is flushed too.
- Priority: rst_n=0 > flush > push/pop.
- Reset (rst_n low at a rising edge) sets:
  - count=0, so out_valid=0 and in_ready=1;
  - out_vec=0 and out_sel=0, with all storage entries zeroed.
- Reset mid-operation discards all entries exactly like flush, and additionally zeroes the data registers.
- in_sel / in_mode / in_en changes while in_valid=0 have no effect.
- No X propagation: data registers are always reset, never left uninitialised.

Test Plan:
- Reset, then IN_W=3, mode 00, in_sel=5, in_en=1, out_ready=1 -> next cycle out_valid=1, out_vec=8'b0010_0000, out_sel=5.
- Modes with IN_W=3, in_sel=2:
  - mode 01 -> 8'b0000_0111;
  - mode 10 -> 8'b1111_1011;
  - mode 11 -> 8'hFF;
  - in_en=0 in any mode -> 8'h00 with out_valid=1.
- Backpressure: out_ready=0, push sel=1 then sel=6 -> in_ready=0 after the second push, and a third request is held. Raise out_ready -> out_vec 8'h02 then 8'h40 in order, and the third request is accepted once a slot frees.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with sel 0..7 mode 00 -> out_vec walks 8'h01..8'h80 on consecutive cycles with no bubbles.
- Flush with count=2 and a simultaneous push -> next cycle out_valid=0, in_ready=1, and the pushed entry never appears.
- rst_n=0 for one cycle with count=1 -> out_valid=0, out_vec=0, out_sel=0. Rerun with IN_W=4, sel=15 mode 01 -> out_vec=16'hFFFF.
